dircc_node_mem_dp: RTL and testbench
====================================

# dircc_node_mem_dp

Parametrised true-dual-port on-chip node memory for DiRCC Nios nodes. It succeeds the fixed 32-bit single-port node RAM with configurable width, depth and read latency. It adds two independent Avalon-MM slaves: port A for the CPU and port B for the mailbox/DMA side. It also adds an optional zero-fill sequencer that runs after reset, with explicit readdatavalid/waitrequest handshakes.

## Interface
Parameters:
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- ADDR_WIDTH, 13: word-address width.
- DEPTH, 5120: number of words; DEPTH ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1: 1 = unregistered RAM output; 2 = extra output register.
- CLEAR_ON_RESET, 1: 1 = zero-fill the whole array after every reset; 0 = contents come from INIT_FILE at configuration only.
- INIT_FILE, "dircc_node_mem.hex": power-up contents.

Ports (x = a, b; BE = DATA_WIDTH/8):
- clk  in  1  single clock for both ports.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  stall request from the reset controller.
- clken  in  1  global clock enable.
- x_address  in  ADDR_WIDTH  word address.
- x_chipselect  in  1  port select.
- x_read  in  1  read request.
- x_write  in  1  write request.
- x_byteenable  in  BE  byte-lane enables for writes.
- x_writedata  in  DATA_WIDTH  write data.
- x_readdata  out  DATA_WIDTH  read data.
- x_readdatavalid  out  1  one-cycle read-data strobe.
- x_waitrequest  out  1  request not accepted this cycle.
- init_done  out  1  high once the array is usable.

## Operation
Control and handshake:
- stall = ~clken | reset_req. While stall is high, no state advances: the FSM, the read pipeline and the outputs all hold.
- x_waitrequest = ~init_done | stall.
- A port accepts a request when chipselect & (read | write) & ~waitrequest.
- Asserting read and write together is illegal; the write takes priority and no readdatavalid is produced.

Init FSM, states CLEAR and READY:
- Reset forces CLEAR with clr_addr = 0 when CLEAR_ON_RESET = 1, and READY otherwise.
- In CLEAR, each unstalled cycle writes 0 to mem[clr_addr] on all lanes and increments clr_addr.
- After the write to DEPTH-1 the FSM moves to READY. init_done = (state == READY), registered.
- Reset asserted mid-clear restarts the sweep from address 0.
- Port requests are never accepted in CLEAR.

Writes:
- Each lane i with byteenable[i] = 1 writes writedata[8i+7:8i]. Lanes with byteenable[i] = 0 are unchanged.

Same-cycle collisions:
- Both ports write the same address: port A wins on lanes enabled in A. B's data is written on lanes enabled only in B.
- One port reads an address the other port writes in the same cycle: the read returns the old data. A port reading while it writes is illegal, as above.

Out-of-range addresses (address ≥ DEPTH):
- Writes are dropped.
- Reads return 0 with a normal readdatavalid.

Reads:
- Reads are fully pipelined; one read per port per cycle is accepted.
- The ports are independent; no arbitration is needed except for collisions.

Reset values:
- x_readdata = 0, x_readdatavalid = 0, init_done = 0 and x_waitrequest = 1 on both ports.
- The pipeline valids are cleared. RAM contents are not reset.

## Timing
- A read accepted at edge t gives x_readdata and x_readdatavalid = 1 after edge t + READ_LATENCY, counting unstalled edges only.
- readdatavalid is high for exactly one unstalled cycle per accepted read.
- A write accepted at edge t is visible to a read accepted at edge t+1 or later, on either port.
- Clear duration is exactly DEPTH unstalled cycles from reset release. init_done rises on the cycle after the final clear write.
- With CLEAR_ON_RESET = 0, init_done rises one cycle after reset release.
- With stall high during the pipeline, x_readdata and x_readdatavalid hold their values: a held valid persists until the next unstalled edge and must not be counted twice.
- With READ_LATENCY = 2, back-to-back reads yield back-to-back valids at the same throughput.

## Test plan
- Clear sweep: DEPTH = 16, CLEAR_ON_RESET = 1, preload 0xDEADBEEF at all addresses, pulse reset -> init_done rises exactly 16 cycles after release; reading all 16 addresses returns 0x00000000.
- Byte enables: write 0x11223344 to A:5, then B writes 0xAABBCCDD to address 5 with be = 4'b0101 -> read returns 0x11BB33DD on both ports.
- Collision: same cycle, A writes 0x0000FFFF be = 4'b0011 and B writes 0xFFFF0000 be = 4'b1111 to address 7, starting from 0 -> mem[7] = 0xFFFFFFFF; repeat with A be = 4'b1111 -> mem[7] = 0x0000FFFF.
- Read during write: mem[3] = 0x1, A reads 3 while B writes 0x2 to 3 -> A returns 0x1; the next read returns 0x2.
- Latency and stall: READ_LATENCY = 2, four back-to-back A reads with clken low for 3 cycles mid-stream -> exactly four valids, in order, each delayed by 3 cycles; waitrequest is high during the stall.
- Reset mid-clear and out-of-range: assert reset at clr_addr = 9 -> the sweep restarts at 0 and takes 16 cycles. Write to address 16 then read 16 -> readdata 0, valid asserted, and the array is unchanged.

Source files
------------

// File: rtl/dircc_node_mem_if.sv
// dircc_node_mem_if -- one Avalon-MM slave port of the DiRCC node memory.
//   master modport : address/chipselect/read/write/byteenable/writedata out,
//                    readdata/readdatavalid/waitrequest in (CPU, mailbox, bench)
//   slave modport  : the memory side of the same signals
interface dircc_node_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 13
);
   localparam int BE = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] address;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [BE-1:0]         byteenable;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  readdatavalid;
   logic                  waitrequest;

   modport master (
      output address, chipselect, read, write, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, chipselect, read, write, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/dircc_node_mem_dp.sv
// dircc_node_mem_dp -- true-dual-port node memory for DiRCC Nios nodes.
//   clk        : single clock for both ports
//   reset      : asynchronous, active-high
//   reset_req  : stall request from the reset controller
//   clken      : global clock enable (low = stall)
//   a          : CPU-side Avalon-MM slave port
//   b          : mailbox/DMA-side Avalon-MM slave port
//   init_done  : high once the array is usable
// Reads are pipelined with READ_LATENCY 1 or 2. An optional zero-fill sweep
// runs after every reset; ports stay in waitrequest until it finishes.
module dircc_node_mem_dp #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 13,
   parameter int DEPTH          = 5120,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1,
   parameter     INIT_FILE      = "dircc_node_mem.hex"
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reset_req,
   input  logic             clken,
   dircc_node_mem_if.slave  a,
   dircc_node_mem_if.slave  b,
   output logic             init_done
);
   localparam int BE     = DATA_WIDTH / 8;
   localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int STAGES = READ_LATENCY - 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [IW-1:0]       LAST    = IW'(DEPTH - 1);

   if (DATA_WIDTH % 8 != 0 || DEPTH > (1 << ADDR_WIDTH) ||
       READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_cfg
      $error("dircc_node_mem_dp (%s): unsupported geometry", INIT_FILE);
   end

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  cs;
      logic                  rd;
      logic                  wr;
      logic [BE-1:0]         be;
      logic [DATA_WIDTH-1:0] wd;
   } req_t;

   typedef enum logic {CLEAR, READY} state_t;
   localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

   // Power-up contents come from the vendor memory-init flow.
   (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

   req_t   [1:0]                 req;
   logic   [1:0]                 in_rng, we, rd_acc;
   logic   [1:0][IW-1:0]         idx;
   logic   [1:0][DATA_WIDTH-1:0] rdata;
   logic   [1:0]                 rvld;
   logic                         stall, busy, clr_we;
   state_t                       state, state_nxt;
   logic   [IW-1:0]              clr_addr, clr_addr_nxt;

   assign stall = ~clken | reset_req;
   assign busy  = ~init_done | stall;

   assign req[0] = '{addr: a.address, cs: a.chipselect, rd: a.read, wr: a.write,
                     be: a.byteenable, wd: a.writedata};
   assign req[1] = '{addr: b.address, cs: b.chipselect, rd: b.read, wr: b.write,
                     be: b.byteenable, wd: b.writedata};

   assign a.readdata      = rdata[0];
   assign a.readdatavalid = rvld[0];
   assign a.waitrequest   = busy;
   assign b.readdata      = rdata[1];
   assign b.readdatavalid = rvld[1];
   assign b.waitrequest   = busy;

   // ---------------- init sweep ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RST_STATE;
         clr_addr  <= '0;
         init_done <= 1'b0;
      end else if (!stall) begin
         state     <= state_nxt;
         clr_addr  <= clr_addr_nxt;
         // registered from next state so init_done rises with the last clear write
         init_done <= (state_nxt == READY);
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      clr_we       = 1'b0;
      case (state)
         CLEAR: if (!stall) begin
            clr_we       = 1'b1;
            clr_addr_nxt = clr_addr + 1'b1;
            if (clr_addr == LAST) state_nxt = READY;
         end
         default: ;
      endcase
   end

   // ---------------- per-port decode and read pipeline ----------------
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [STAGES:0]                 vld_pipe;
      logic [STAGES:0][DATA_WIDTH-1:0] dat_pipe;

      assign in_rng[p] = {1'b0, req[p].addr} < DEPTH_W;
      assign idx[p]    = req[p].addr[IW-1:0];
      // busy already covers stall and the clear sweep
      assign we[p]     = req[p].cs & req[p].wr & ~busy & in_rng[p];
      // read+write together is treated as a write only
      assign rd_acc[p] = req[p].cs & req[p].rd & ~req[p].wr & ~busy;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
         end else if (!stall) begin
            vld_pipe[0] <= rd_acc[p];
            // out-of-range reads complete normally with zero data
            if (rd_acc[p]) dat_pipe[0] <= in_rng[p] ? mem[idx[p]] : '0;
            for (int k = 1; k <= STAGES; k++) begin
               vld_pipe[k] <= vld_pipe[k-1];
               dat_pipe[k] <= dat_pipe[k-1];
            end
         end
      end

      assign rdata[p] = dat_pipe[STAGES];
      assign rvld[p]  = vld_pipe[STAGES];
   end

   // ---------------- array writes ----------------
   // Clear and port writes never coincide: ports wait while clearing.
   // On a same-address collision A owns its enabled lanes; B fills the rest.
   always_ff @(posedge clk) begin
      if (clr_we) mem[clr_addr] <= '0;
      for (int i = 0; i < BE; i++) begin
         if (we[1] && req[1].be[i] &&
             !(we[0] && req[0].be[i] && idx[0] == idx[1]))
            mem[idx[1]][8*i +: 8] <= req[1].wd[8*i +: 8];
         if (we[0] && req[0].be[i])
            mem[idx[0]][8*i +: 8] <= req[0].wd[8*i +: 8];
      end
   end
endmodule

// File: tb/tb_dircc_node_mem_dp.sv
// tb_dircc_node_mem_dp -- directed, table-driven bench for dircc_node_mem_dp.
//   dut  : DEPTH 16, READ_LATENCY 2, zero-fill after reset
//   dut1 : DEPTH 16, READ_LATENCY 1, no zero-fill
`timescale 1ns/1ps
module tb_dircc_node_mem_dp;
   localparam int DW = 32, AW = 5, DEP = 16;

   logic clk = 1'b0, reset = 1'b1, reset_req = 1'b0, clken = 1'b1;
   logic init_done, init_done1;
   int   checks = 0, errors = 0, cyc = 0;

   dircc_node_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if(), b_if(), c_if(), d_if();

   dircc_node_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP),
                       .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
      .a(a_if), .b(b_if), .init_done(init_done));

   dircc_node_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP),
                       .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut1 (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
      .a(c_if), .b(d_if), .init_done(init_done1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // counts a valid once, in the cycle whose closing edge is unstalled
   logic           mon_en = 1'b0;
   logic [DW-1:0]  mon_d[$];
   int             mon_t[$];
   always @(negedge clk)
      if (mon_en && a_if.readdatavalid && clken && !reset_req) begin
         mon_d.push_back(a_if.readdata);
         mon_t.push_back(cyc);
      end

   typedef struct {
      int             p;
      bit             wr;
      logic [AW-1:0]  ad;
      logic [3:0]     be;
      logic [DW-1:0]  wd;
      logic [DW-1:0]  exp;
   } vec_t;
   vec_t vecs[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input int p, input logic rd, input logic wr, input logic [AW-1:0] ad,
                        input logic [3:0] be, input logic [DW-1:0] wd);
      if (p == 0) begin
         a_if.chipselect = rd | wr; a_if.read = rd; a_if.write = wr;
         a_if.address = ad; a_if.byteenable = be; a_if.writedata = wd;
      end else begin
         b_if.chipselect = rd | wr; b_if.read = rd; b_if.write = wr;
         b_if.address = ad; b_if.byteenable = be; b_if.writedata = wd;
      end
   endtask

   task automatic idle_all();
      drive(0, 0, 0, '0, '0, '0);
      drive(1, 0, 0, '0, '0, '0);
   endtask

   function automatic logic rdv(input int p);
      return (p == 0) ? a_if.readdatavalid : b_if.readdatavalid;
   endfunction

   function automatic logic [DW-1:0] rdd(input int p);
      return (p == 0) ? a_if.readdata : b_if.readdata;
   endfunction

   task automatic wr(input int p, input logic [AW-1:0] ad, input logic [3:0] be, input logic [DW-1:0] wd);
      drive(p, 0, 1, ad, be, wd); tick; drive(p, 0, 0, '0, '0, '0);
   endtask

   // latency-2 read: nothing after the accept edge, data one edge later, gone the next
   task automatic rd_chk(input int p, input logic [AW-1:0] ad, input logic [DW-1:0] exp, input string nm);
      drive(p, 1, 0, ad, '0, '0); tick; drive(p, 0, 0, '0, '0, '0);
      chk({nm, " early"}, 32'(rdv(p)), 32'd0);
      tick;
      chk({nm, " vld"}, 32'(rdv(p)), 32'd1);
      chk({nm, " data"}, rdd(p), exp);
      tick;
      chk({nm, " once"}, 32'(rdv(p)), 32'd0);
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (!init_done && n < 60) begin tick; n++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, u, base;
      idle_all();
      c_if.chipselect = 0; c_if.read = 0; c_if.write = 0; c_if.address = '0;
      c_if.byteenable = '0; c_if.writedata = '0;
      d_if.chipselect = 0; d_if.read = 0; d_if.write = 0; d_if.address = '0;
      d_if.byteenable = '0; d_if.writedata = '0;

      vecs[0]  = '{0, 1'b1, 5'd5,  4'hF, 32'h11223344, 32'h0};
      vecs[1]  = '{1, 1'b1, 5'd5,  4'h5, 32'hAABBCCDD, 32'h0};
      vecs[2]  = '{0, 1'b0, 5'd5,  4'h0, 32'h0,        32'h11BB33DD};
      vecs[3]  = '{1, 1'b0, 5'd5,  4'h0, 32'h0,        32'h11BB33DD};
      vecs[4]  = '{1, 1'b1, 5'd0,  4'hF, 32'h01234567, 32'h0};
      vecs[5]  = '{0, 1'b0, 5'd0,  4'h0, 32'h0,        32'h01234567};
      vecs[6]  = '{0, 1'b1, 5'd15, 4'h8, 32'hA5FFFFFF, 32'h0};
      vecs[7]  = '{1, 1'b0, 5'd15, 4'h0, 32'h0,        32'hA5000000};
      vecs[8]  = '{0, 1'b1, 5'd15, 4'h2, 32'h12345A78, 32'h0};
      vecs[9]  = '{0, 1'b0, 5'd15, 4'h0, 32'h0,        32'hA5005A00};
      vecs[10] = '{0, 1'b1, 5'd16, 4'hF, 32'hCAFEF00D, 32'h0};
      vecs[11] = '{0, 1'b0, 5'd16, 4'h0, 32'h0,        32'h0};
      vecs[12] = '{1, 1'b0, 5'd0,  4'h0, 32'h0,        32'h01234567};
      vecs[13] = '{1, 1'b1, 5'd31, 4'hF, 32'h12345678, 32'h0};
      vecs[14] = '{1, 1'b0, 5'd31, 4'h0, 32'h0,        32'h0};
      vecs[15] = '{0, 1'b0, 5'd15, 4'h0, 32'h0,        32'hA5005A00};
      vecs[16] = '{0, 1'b1, 5'd5,  4'h0, 32'hFFFFFFFF, 32'h0};
      vecs[17] = '{1, 1'b0, 5'd5,  4'h0, 32'h0,        32'h11BB33DD};

      // reset state
      #2;
      chk("rst a rdata", a_if.readdata, 32'h0);
      chk("rst a rvld", 32'(a_if.readdatavalid), 32'd0);
      chk("rst b rvld", 32'(b_if.readdatavalid), 32'd0);
      chk("rst a wait", 32'(a_if.waitrequest), 32'd1);
      chk("rst b wait", 32'(b_if.waitrequest), 32'd1);
      chk("rst init", 32'(init_done), 32'd0);
      chk("rst init1", 32'(init_done1), 32'd0);
      tick; tick;
      reset = 1'b0;

      // first sweep; the no-clear instance is ready after one edge
      n = 0;
      while (!init_done && n < 60) begin
         tick; n++;
         if (n == 1) chk("init1 one cycle", 32'(init_done1), 32'd1);
      end
      chk("clear cycles", n, 16);
      chk("wait low", 32'(a_if.waitrequest), 32'd0);

      // latency-1 instance
      c_if.chipselect = 1; c_if.write = 1; c_if.address = 5'd2;
      c_if.byteenable = 4'hF; c_if.writedata = 32'h00000077;
      tick;
      c_if.write = 0; c_if.read = 1;
      tick;
      c_if.read = 0; c_if.chipselect = 0;
      chk("rl1 vld", 32'(c_if.readdatavalid), 32'd1);
      chk("rl1 data", c_if.readdata, 32'h00000077);
      tick;
      chk("rl1 once", 32'(c_if.readdatavalid), 32'd0);

      // preload, then reset must zero the whole array in DEPTH cycles
      for (int i = 0; i < DEP; i++) wr(i % 2, AW'(i), 4'hF, 32'hDEADBEEF);
      rd_chk(0, 5'd4, 32'hDEADBEEF, "preload");
      reset = 1'b1; tick; reset = 1'b0;
      wait_init(n);
      chk("reclear cycles", n, 16);
      for (int i = 0; i < DEP; i++) rd_chk(i % 2, AW'(i), 32'h0, $sformatf("cleared%0d", i));

      // directed vector table
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].wr) wr(vecs[i].p, vecs[i].ad, vecs[i].be, vecs[i].wd);
         else rd_chk(vecs[i].p, vecs[i].ad, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // same-address write collisions
      drive(0, 0, 1, 5'd7, 4'h3, 32'h0000FFFF); drive(1, 0, 1, 5'd7, 4'hF, 32'hFFFF0000);
      tick; idle_all();
      rd_chk(0, 5'd7, 32'hFFFFFFFF, "coll partial");
      drive(0, 0, 1, 5'd7, 4'hF, 32'h0000FFFF); drive(1, 0, 1, 5'd7, 4'hF, 32'hFFFF0000);
      tick; idle_all();
      rd_chk(1, 5'd7, 32'h0000FFFF, "coll full");

      // read on A while B writes the same address returns old data
      wr(0, 5'd3, 4'hF, 32'h1);
      drive(0, 1, 0, 5'd3, 4'h0, 32'h0); drive(1, 0, 1, 5'd3, 4'hF, 32'h2);
      tick; idle_all();
      tick;
      chk("rdw vld", 32'(rdv(0)), 32'd1);
      chk("rdw old", rdd(0), 32'h1);
      tick;
      rd_chk(1, 5'd3, 32'h2, "rdw new");

      // write then cross-port read on the very next edge
      drive(0, 0, 1, 5'd9, 4'hF, 32'h55AA55AA); tick;
      drive(0, 0, 0, '0, '0, '0); drive(1, 1, 0, 5'd9, 4'h0, 32'h0); tick;
      idle_all(); tick;
      chk("w2r vld", 32'(rdv(1)), 32'd1);
      chk("w2r data", rdd(1), 32'h55AA55AA);
      tick;

      // reset_req alone stalls the ports
      reset_req = 1'b1; #2;
      chk("rreq wait", 32'(b_if.waitrequest), 32'd1);
      reset_req = 1'b0;
      tick;

      // four back-to-back reads with a 3-cycle clken gap
      for (int i = 0; i < 4; i++) wr(0, AW'(10 + i), 4'hF, 32'h10000000 + i);
      base = 0;
      mon_en = 1'b1;
      for (int s = 0; s < 10; s++) begin
         clken = !(s >= 2 && s <= 4);
         if (s < 2)       drive(0, 1, 0, AW'(10 + s), 4'h0, 32'h0);
         else if (s <= 5) drive(0, 1, 0, 5'd12, 4'h0, 32'h0);
         else if (s == 6) drive(0, 1, 0, 5'd13, 4'h0, 32'h0);
         else             drive(0, 0, 0, '0, '0, '0);
         @(negedge clk);
         if (s == 0) base = cyc;
         if (s >= 2 && s <= 4) chk($sformatf("stall wait s%0d", s), 32'(a_if.waitrequest), 32'd1);
         @(posedge clk); #1;
      end
      tick;
      mon_en = 1'b0;
      clken = 1'b1;
      chk("stall valids", mon_d.size(), 4);
      if (mon_d.size() == 4)
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall data%0d", k), mon_d[k], 32'h10000000 + k);
            chk($sformatf("stall time%0d", k), mon_t[k] - base, 5 + k);
         end

      // reset at clr_addr 9 restarts the sweep; two stalled cycles inside it
      reset = 1'b1; tick; reset = 1'b0;
      for (int k = 0; k < 9; k++) tick;
      chk("mid init low", 32'(init_done), 32'd0);
      reset = 1'b1; tick;
      chk("mid rst wait", 32'(a_if.waitrequest), 32'd1);
      reset = 1'b0;
      n = 0; u = 0;
      while (!init_done && n < 60) begin
         clken = (n != 5 && n != 6);
         tick;
         if (clken) u++;
         n++;
      end
      clken = 1'b1;
      chk("restart unstalled", u, 16);
      chk("restart total", n, 18);
      rd_chk(1, 5'd15, 32'h0, "restart cleared");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
